// File: rtl/toll_pkg.sv
// toll_pkg: frame field layout, lane state encoding and fare selection shared by the toll plaza blocks
package toll_pkg;

    localparam int FRM_EV   = 0;
    localparam int FRM_TG   = 1;
    localparam int FRM_VEH  = 2;
    localparam int FRM_LANE = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    function automatic int fare_of(input logic ev, input int base_fare, input int ev_fare);
        return ev ? ev_fare : base_fare;
    endfunction

endpackage

// File: rtl/toll_lane_fsm.sv
// toll_lane_fsm: one lane's gate timer, tailgate alert hold, EV flag and single pending fare slot
module toll_lane_fsm #(
    parameter int GATE_OPEN_CYC  = 100,
    parameter int ALERT_HOLD_CYC = 50,
    parameter int FARE_W         = 16,
    parameter int BASE_FARE      = 100,
    parameter int EV_FARE        = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              veh,
    input  logic              tg,
    input  logic              ev,
    input  logic              grant,
    output logic              gate_open,
    output logic              tailgate_alert,
    output logic              ev_discount,
    output logic              pend_valid,
    output logic [FARE_W-1:0] pend_amt,
    output logic              accept,
    output logic              overrun
);
    import toll_pkg::*;

    localparam int GW = $clog2(GATE_OPEN_CYC + 1);
    localparam int AW = $clog2(ALERT_HOLD_CYC + 1);

    logic [0:0]    state;
    logic [GW-1:0] gate_tmr;
    logic [AW-1:0] alert_cnt;

    // a full slot that is being granted this cycle can take the new vehicle
    assign accept         = veh && (!pend_valid || grant);
    assign overrun        = veh && pend_valid && !grant;
    assign gate_open      = state == ST_OPEN;
    assign tailgate_alert = alert_cnt != '0;

    // gate FSM: reload on accept, otherwise count down and close after the last cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            gate_tmr    <= '0;
            ev_discount <= 1'b0;
        end else if (accept) begin
            state       <= ST_OPEN;
            gate_tmr    <= GW'(GATE_OPEN_CYC - 1);
            ev_discount <= ev;
        end else if (state == ST_OPEN) begin
            if (gate_tmr == '0) begin
                state       <= ST_IDLE;
                ev_discount <= 1'b0;
            end else begin
                gate_tmr <= gate_tmr - 1'b1;
            end
        end
    end

    // tailgate alert hold counter, independent of the gate
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            alert_cnt <= '0;
        else if (tg)
            alert_cnt <= AW'(ALERT_HOLD_CYC);
        else if (alert_cnt != '0)
            alert_cnt <= alert_cnt - 1'b1;
    end

    // pending fare slot: a refill wins over a same-cycle grant so no record is lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_amt   <= '0;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend_amt   <= FARE_W'(fare_of(ev, BASE_FARE, EV_FARE));
        end else if (grant) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/toll_plaza_ctrl.sv
// toll_plaza_ctrl: decodes UART lane frames, runs per-lane gates and arbitrates fare records round-robin
module toll_plaza_ctrl #(
    parameter int NUM_LANES      = 4,
    parameter int LANE_W         = 2,
    parameter int GATE_OPEN_CYC  = 100,
    parameter int ALERT_HOLD_CYC = 50,
    parameter int FARE_W         = 16,
    parameter int BASE_FARE      = 100,
    parameter int EV_FARE        = 80,
    parameter int COUNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_valid,
    input  logic [LANE_W+2:0]    uart_data,
    output logic [NUM_LANES-1:0] gate_open,
    output logic [NUM_LANES-1:0] tailgate_alert,
    output logic [NUM_LANES-1:0] ev_discount,
    output logic                 fare_valid,
    input  logic                 fare_ready,
    output logic [LANE_W-1:0]    fare_lane,
    output logic [FARE_W-1:0]    fare_amount,
    output logic                 fare_overrun,
    output logic                 bad_lane,
    output logic [COUNT_W-1:0]   vehicle_count
);
    import toll_pkg::*;

    logic [LANE_W-1:0]    lane_id, rr_ptr, sel, idx;
    logic                 frame_ok, found, load_en;
    logic [NUM_LANES-1:0] pend_valid, grant, accept, overrun;
    logic [FARE_W-1:0]    pend_amt [NUM_LANES];

    function automatic int wrap(input int v);
        return v >= NUM_LANES ? v - NUM_LANES : v;
    endfunction

    assign lane_id  = uart_data[FRM_LANE +: LANE_W];
    assign frame_ok = uart_valid && (int'(lane_id) < NUM_LANES);
    assign load_en  = !fare_valid || fare_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        toll_lane_fsm #(
            .GATE_OPEN_CYC (GATE_OPEN_CYC),
            .ALERT_HOLD_CYC(ALERT_HOLD_CYC),
            .FARE_W        (FARE_W),
            .BASE_FARE     (BASE_FARE),
            .EV_FARE       (EV_FARE)
        ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .veh           (frame_ok && uart_data[FRM_VEH] && lane_id == LANE_W'(i)),
            .tg            (frame_ok && uart_data[FRM_TG] && lane_id == LANE_W'(i)),
            .ev            (uart_data[FRM_EV]),
            .grant         (grant[i]),
            .gate_open     (gate_open[i]),
            .tailgate_alert(tailgate_alert[i]),
            .ev_discount   (ev_discount[i]),
            .pend_valid    (pend_valid[i]),
            .pend_amt      (pend_amt[i]),
            .accept        (accept[i]),
            .overrun       (overrun[i])
        );
    end

    // round-robin pick: scan backwards so the pending lane nearest rr_ptr wins
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = LANE_W'(wrap(int'(rr_ptr) + i));
            if (pend_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // grant only when the fare register is free or being drained this cycle
    always_comb begin
        grant = '0;
        if (load_en && found)
            grant[sel] = 1'b1;
    end

    // fare output register; rr_ptr points at the lane after the last grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fare_valid  <= 1'b0;
            fare_lane   <= '0;
            fare_amount <= '0;
            rr_ptr      <= '0;
        end else if (load_en) begin
            fare_valid <= found;
            if (found) begin
                fare_lane   <= sel;
                fare_amount <= pend_amt[sel];
                rr_ptr      <= LANE_W'(wrap(int'(sel) + 1));
            end
        end
    end

    // status pulses and saturating vehicle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_lane      <= 1'b0;
            fare_overrun  <= 1'b0;
            vehicle_count <= '0;
        end else begin
            bad_lane     <= uart_valid && !frame_ok;
            fare_overrun <= |overrun;
            if (|accept && vehicle_count != '1)
                vehicle_count <= vehicle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_toll_plaza_ctrl.sv
// tb_toll_plaza_ctrl: directed and random stimulus checked against a cycle-level model of the toll rules
module tb_toll_plaza_ctrl;

    localparam int NL = 4;
    localparam int G  = 100;
    localparam int A  = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        uart_valid = 1'b0;
    logic [4:0]  uart_data  = '0;
    logic        fare_ready = 1'b0;
    logic [3:0]  gate_open, tailgate_alert, ev_discount;
    logic        fare_valid, fare_overrun, bad_lane;
    logic [1:0]  fare_lane;
    logic [15:0] fare_amount, vehicle_count;

    logic        v3 = 1'b0;
    logic [4:0]  d3 = '0;
    logic        r3 = 1'b1;
    logic [2:0]  gate3, alert3, evd3;
    logic        fv3, ovr3, bad3;
    logic [1:0]  fl3, cnt3;
    logic [15:0] fa3;

    int checks = 0;
    int errors = 0;

    int m_open[NL], m_alert[NL], m_pa[NL];
    bit m_ev[NL], m_pv[NL];
    bit m_fv, m_ovr, m_bad;
    int m_fl, m_fa, m_rr, m_cnt;

    toll_plaza_ctrl dut (
        .clk(clk), .reset(reset), .uart_valid(uart_valid), .uart_data(uart_data),
        .gate_open(gate_open), .tailgate_alert(tailgate_alert), .ev_discount(ev_discount),
        .fare_valid(fare_valid), .fare_ready(fare_ready), .fare_lane(fare_lane),
        .fare_amount(fare_amount), .fare_overrun(fare_overrun), .bad_lane(bad_lane),
        .vehicle_count(vehicle_count)
    );

    toll_plaza_ctrl #(.NUM_LANES(3), .COUNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .uart_valid(v3), .uart_data(d3),
        .gate_open(gate3), .tailgate_alert(alert3), .ev_discount(evd3),
        .fare_valid(fv3), .fare_ready(r3), .fare_lane(fl3),
        .fare_amount(fa3), .fare_overrun(ovr3), .bad_lane(bad3),
        .vehicle_count(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] fr(input int lane, input bit veh, input bit tg, input bit ev);
        return {2'(lane), veh, tg, ev};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_open[i] = 0; m_alert[i] = 0; m_pa[i] = 0; m_ev[i] = 0; m_pv[i] = 0;
        end
        m_fv = 0; m_ovr = 0; m_bad = 0; m_fl = 0; m_fa = 0; m_rr = 0; m_cnt = 0;
    endtask

    task automatic model_update(input logic v, input logic [4:0] d, input logic rdy);
        int lane;
        int g;
        bit ld;
        bit hit;
        lane = int'(d[4:3]);
        g = -1;
        ld = !m_fv || rdy;
        m_ovr = 0;
        m_bad = v && lane >= NL;
        if (ld) begin
            for (int k = 0; k < NL; k++)
                if (g < 0 && m_pv[(m_rr + k) % NL]) g = (m_rr + k) % NL;
            m_fv = g >= 0;
            if (g >= 0) begin
                m_fl = g; m_fa = m_pa[g]; m_pv[g] = 0; m_rr = (g + 1) % NL;
            end
        end
        for (int i = 0; i < NL; i++) begin
            hit = v && lane == i;
            if (hit && d[2] && !m_pv[i]) begin
                m_pv[i] = 1; m_pa[i] = d[0] ? 80 : 100; m_open[i] = G; m_ev[i] = d[0];
                if (m_cnt < 65535) m_cnt++;
            end else begin
                if (hit && d[2]) m_ovr = 1;
                if (m_open[i] > 0) begin
                    m_open[i]--;
                    if (m_open[i] == 0) m_ev[i] = 0;
                end
            end
            if (hit && d[1]) m_alert[i] = A;
            else if (m_alert[i] > 0) m_alert[i]--;
        end
    endtask

    task automatic check_all();
        logic [3:0] eg, ea, ee;
        for (int i = 0; i < NL; i++) begin
            eg[i] = m_open[i] > 0;
            ea[i] = m_alert[i] > 0;
            ee[i] = m_ev[i] && m_open[i] > 0;
        end
        chk("gate_open", gate_open, eg);
        chk("tailgate_alert", tailgate_alert, ea);
        chk("ev_discount", ev_discount, ee);
        chk("fare_valid", fare_valid, m_fv);
        chk("fare_lane", fare_lane, m_fl);
        chk("fare_amount", fare_amount, m_fa);
        chk("fare_overrun", fare_overrun, m_ovr);
        chk("bad_lane", bad_lane, m_bad);
        chk("vehicle_count", vehicle_count, m_cnt);
    endtask

    task automatic step(input logic v, input logic [4:0] d, input logic rdy);
        uart_valid = v;
        uart_data  = d;
        fare_ready = rdy;
        @(posedge clk);
        model_update(v, d, rdy);
        #1;
        check_all();
    endtask

    initial begin
        int n;
        int q[$];
        int exp_rr[4];
        int lanes3[5];
        exp_rr = '{0, 1, 3, 0};
        lanes3 = '{0, 1, 2, 0, 1};
        model_reset();
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_cnt3", cnt3, 0);
        chk("rst_fv3", fv3, 0);
        @(negedge clk) reset = 1'b0;

        // lane 2 EV vehicle with billing ready
        step(1, fr(2, 1, 0, 1), 1);
        chk("l2_gate_n1", gate_open[2], 1);
        chk("l2_fv_n1", fare_valid, 0);
        step(0, '0, 1);
        chk("l2_fv_n2", fare_valid, 1);
        chk("l2_lane", fare_lane, 2);
        chk("l2_amt", fare_amount, 80);
        n = 1;
        for (int k = 0; k < 150; k++) begin
            if (gate_open[2] === 1'b1) n++;
            chk("l2_evd_window", ev_discount[2], gate_open[2]);
            step(0, '0, 1);
        end
        chk("l2_gate_cycles", n, 100);

        // three lanes back-to-back with billing stalled, then a refill and an overrun on lane 0
        step(1, fr(0, 1, 0, 0), 0);
        step(1, fr(1, 1, 0, 0), 0);
        step(1, fr(3, 1, 0, 0), 0);
        step(1, fr(0, 1, 0, 0), 0);
        chk("rr_count", vehicle_count, 5);
        step(1, fr(0, 1, 0, 0), 0);
        chk("rr_overrun", fare_overrun, 1);
        chk("rr_count_hold", vehicle_count, 5);
        for (int k = 0; k < 5; k++) begin
            step(0, '0, 0);
            chk("rr_stall_valid", fare_valid, 1);
            chk("rr_stall_lane", fare_lane, 0);
        end
        for (int k = 0; k < 12; k++) begin
            if (fare_valid === 1'b1) q.push_back(int'(fare_lane));
            step(0, '0, 1);
        end
        chk("rr_records", q.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("rr_order", k < q.size() ? q[k] : -1, exp_rr[k]);

        // tailgate on lane 3 at cycle 0 and 30
        step(1, fr(3, 0, 1, 0), 0);
        for (int t = 1; t <= 90; t++) begin
            chk("tg_alert3", tailgate_alert[3], t <= 80);
            step(t == 30, t == 30 ? fr(3, 0, 1, 0) : 5'd0, 0);
        end

        // empty frame has no effect
        step(1, fr(1, 0, 0, 1), 1);

        // random traffic
        for (int k = 0; k < 400; k++)
            step(1'($urandom), 5'($urandom), ($urandom % 4) != 0);

        // asynchronous reset with lane 1 open
        step(1, fr(1, 1, 0, 0), 0);
        repeat (3) step(0, '0, 0);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_async_gate1", gate_open[1], 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        step(0, '0, 0);
        chk("rst_release_fv", fare_valid, 0);

        // out-of-range lane on a three-lane instance
        v3 = 1'b1;
        d3 = fr(3, 1, 1, 0);
        step(0, '0, 0);
        v3 = 1'b0;
        chk("bad3_pulse", bad3, 1);
        chk("bad3_gate", gate3, 0);
        chk("bad3_alert", alert3, 0);
        chk("bad3_cnt", cnt3, 0);
        chk("bad3_fv", fv3, 0);
        step(0, '0, 0);
        chk("bad3_pulse_end", bad3, 0);

        // vehicle counter saturation on the narrow-counter instance
        for (int k = 0; k < 5; k++) begin
            v3 = 1'b1;
            d3 = fr(lanes3[k], 1, 0, 0);
            step(0, '0, 0);
            chk("cnt3_sat", cnt3, (k + 1 > 3) ? 3 : k + 1);
        end
        v3 = 1'b0;
        chk("cnt3_no_overrun", ovr3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
